// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM state type, ADC frame geometry and default window length.
package adc_pkg;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, QUIET} state_t;
    localparam int ADC_BITS = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS = 4;
    localparam int WINDOW_CYCLES_DEFAULT = 40000;
endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: CLK_DIV half-period divider; sclk idles high, rise_stb marks the cycle sclk went high.
module adc_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    output logic sclk,
    output logic rise_stb
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic last;
    assign last = cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            sclk <= 1'b1;
            rise_stb <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sclk <= 1'b1;
            rise_stb <= 1'b0;
        end else begin
            cnt <= last ? '0 : cnt + CW'(1);
            sclk <= cnt == '0 ? !sclk : sclk;
            rise_stb <= cnt == '0 && !sclk;
        end
    end
endmodule

// File: rtl/adc_window_sampler.sv
// adc_window_sampler: drives an AD7476-style ADC inside a timed measurement window.
// Optional ADC_FRAME_CHECK_EN drops frames with non-zero leading bits and flags frame_err.
module adc_window_sampler
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int SAMPLE_PERIOD = 100,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                swiptAlive,
    input  logic                start,
    input  logic                adc_sdata,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [ADC_BITS-1:0] ADC,
    output logic                sample_valid,
    output logic                measure,
    output logic                window_done,
`ifdef ADC_FRAME_CHECK_EN
    output logic                frame_err,
`endif
    output logic [CNT_W-1:0]    sample_cnt
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int WW = $clog2(WINDOW_CYCLES + 1);
    localparam int BW = $clog2(FRAME_BITS);
`ifdef ADC_FRAME_CHECK_EN
    localparam int SW = FRAME_BITS;
`else
    localparam int SW = ADC_BITS;
`endif
    state_t state;
    logic [DW-1:0] dcnt;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] per_cnt;
    logic [WW-1:0] win_cnt;
    logic [SW-1:0] shreg;
    logic rise_stb, last_rise, sclk_en, dlast, win_end, frame_ok, capture;

    assign last_rise = rise_stb && bit_cnt == BW'(FRAME_BITS - 1);
    // Drop the enable on the final rise so sclk parks high without an extra falling edge.
    assign sclk_en = state == SHIFT && swiptAlive && !last_rise;
    assign dlast = dcnt == DW'(CLK_DIV - 1);
    assign win_end = measure && win_cnt == '0;
    assign capture = state == CS_HOLD && dcnt == '0 && measure;
`ifdef ADC_FRAME_CHECK_EN
    assign frame_ok = shreg[SW-1 -: LEAD_BITS] == '0;
`else
    assign frame_ok = 1'b1;
`endif

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk(clk),
        .nrst(nrst),
        .en(sclk_en),
        .sclk(adc_sclk),
        .rise_stb(rise_stb)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            dcnt <= '0;
            bit_cnt <= '0;
            per_cnt <= '0;
            win_cnt <= '0;
            shreg <= '0;
            adc_cs_n <= 1'b1;
            ADC <= '0;
            sample_valid <= 1'b0;
            measure <= 1'b0;
            window_done <= 1'b0;
            sample_cnt <= '0;
`ifdef ADC_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else if (!swiptAlive) begin
            state <= IDLE;
            dcnt <= '0;
            adc_cs_n <= 1'b1;
            measure <= 1'b0;
            sample_valid <= 1'b0;
            window_done <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            window_done <= win_end;
            per_cnt <= per_cnt + PW'(1);
            if (measure) win_cnt <= win_cnt - WW'(1);
            if (win_end) measure <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= CS_SETUP;
                    adc_cs_n <= 1'b0;
                    measure <= 1'b1;
                    win_cnt <= WW'(WINDOW_CYCLES - 1);
                    sample_cnt <= '0;
                    per_cnt <= '0;
                    dcnt <= '0;
`ifdef ADC_FRAME_CHECK_EN
                    frame_err <= 1'b0;
`endif
                end
                CS_SETUP: begin
                    dcnt <= dlast ? '0 : dcnt + DW'(1);
                    if (dlast) state <= SHIFT;
                    bit_cnt <= '0;
                end
                SHIFT: if (rise_stb) begin
                    shreg <= {shreg[SW-2:0], adc_sdata};
                    bit_cnt <= bit_cnt + BW'(1);
                    if (last_rise) state <= CS_HOLD;
                end
                CS_HOLD: begin
                    dcnt <= dlast ? '0 : dcnt + DW'(1);
                    if (capture && frame_ok) begin
                        ADC <= shreg[ADC_BITS-1:0];
                        sample_valid <= 1'b1;
                        if (~&sample_cnt) sample_cnt <= sample_cnt + CNT_W'(1);
                    end
`ifdef ADC_FRAME_CHECK_EN
                    if (capture && !frame_ok) frame_err <= 1'b1;
`endif
                    if (dlast) begin
                        adc_cs_n <= 1'b1;
                        state <= QUIET;
                    end
                end
                QUIET: if (per_cnt == PW'(SAMPLE_PERIOD - 1)) begin
                    state <= measure ? CS_SETUP : IDLE;
                    adc_cs_n <= !measure;
                    per_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_window_sampler.sv
// tb_adc_window_sampler: directed table-driven bench with a serial ADC model and pin monitors.
module tb_adc_window_sampler;
    logic clk = 1'b0, nrst, swiptAlive, start, adc_sdata;
    logic adc_cs_n, adc_sclk, sample_valid, measure, window_done;
    logic [11:0] ADC;
    logic [15:0] sample_cnt;
`ifdef ADC_FRAME_CHECK_EN
    logic frame_err;
`endif
    logic [15:0] frame_word = 16'h0000;
    int n_cmp = 0, n_bad = 0;
    int n_sv = 0, n_wd = 0, n_meas = 0, n_csfall = 0, cs_run = 0, cs_len = 0;
    logic prev_cs = 1'b1;

    always #5 clk = ~clk;

    adc_window_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .WINDOW_CYCLES(1000), .CNT_W(16)) dut (
        .clk(clk),
        .nrst(nrst),
        .swiptAlive(swiptAlive),
        .start(start),
        .adc_sdata(adc_sdata),
        .adc_cs_n(adc_cs_n),
        .adc_sclk(adc_sclk),
        .ADC(ADC),
        .sample_valid(sample_valid),
        .measure(measure),
        .window_done(window_done),
`ifdef ADC_FRAME_CHECK_EN
        .frame_err(frame_err),
`endif
        .sample_cnt(sample_cnt)
    );

    // ADC model: cs_n fall rewinds to bit 15, each sclk fall presents the next bit.
    initial begin
        int bi;
        bi = 15;
        adc_sdata = 1'b0;
        forever begin
            @(negedge adc_sclk or negedge adc_cs_n);
            if (adc_sclk) bi = 15;
            else if (!adc_cs_n && bi >= 0) begin
                adc_sdata = frame_word[bi];
                bi--;
            end
        end
    end

    always @(negedge clk) begin
        if (sample_valid) n_sv++;
        if (window_done) n_wd++;
        if (measure) n_meas++;
        if (prev_cs && !adc_cs_n) n_csfall++;
        if (!adc_cs_n) cs_run++;
        else if (cs_run != 0) begin
            cs_len = cs_run;
            cs_run = 0;
        end
        prev_cs = adc_cs_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] word;
        logic [11:0] exp_adc;
        int          exp_n;
        logic        exp_ferr;
    } vec_t;

    vec_t v[6];
    int b_sv, b_wd, b_ms, b_cf;

    initial begin
        v[0] = '{16'h0A5C, 12'hA5C, 10, 1'b0};
        v[1] = '{16'h07FF, 12'h7FF, 10, 1'b0};
`ifdef ADC_FRAME_CHECK_EN
        v[2] = '{16'h4123, 12'h7FF, 0, 1'b1};
`else
        v[2] = '{16'h4123, 12'h123, 10, 1'b0};
`endif
        v[3] = '{16'h0FFF, 12'hFFF, 10, 1'b0};
        v[4] = '{16'h0000, 12'h000, 10, 1'b0};
        v[5] = '{16'h0800, 12'h800, 10, 1'b0};
        nrst = 1'b0;
        swiptAlive = 1'b1;
        start = 1'b0;
        tick(3);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 1);
        chk("rst_adc", ADC, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_measure", measure, 0);
        chk("rst_done", window_done, 0);
        chk("rst_cnt", sample_cnt, 0);
`ifdef ADC_FRAME_CHECK_EN
        chk("rst_ferr", frame_err, 0);
`endif
        nrst = 1'b1;
        tick(5);

        for (int r = 0; r < 6; r++) begin
            b_sv = n_sv;
            b_wd = n_wd;
            b_ms = n_meas;
            frame_word = v[r].word;
            pulse_start();
`ifdef ADC_FRAME_CHECK_EN
            chk("ferr_cleared", frame_err, 0);
`endif
            tick(1200);
            chk("valid_count", n_sv - b_sv, v[r].exp_n);
            chk("adc_value", ADC, v[r].exp_adc);
            chk("sample_cnt", sample_cnt, v[r].exp_n);
            chk("window_done_count", n_wd - b_wd, 1);
            chk("measure_len", n_meas - b_ms, 1000);
            chk("cs_low_len", cs_len, 68);
`ifdef ADC_FRAME_CHECK_EN
            chk("frame_err", frame_err, v[r].exp_ferr);
`endif
        end

        // Asynchronous reset while the first frame is shifting.
        pulse_start();
        tick(30);
        chk("pre_reset_cs_low", adc_cs_n, 0);
        #2 nrst = 1'b0;
        #1;
        chk("async_cs_n", adc_cs_n, 1);
        chk("async_sclk", adc_sclk, 1);
        chk("async_measure", measure, 0);
        chk("async_adc", ADC, 0);
        chk("async_valid", sample_valid, 0);
        chk("async_cnt", sample_cnt, 0);
        @(negedge clk);
        nrst = 1'b1;
        b_cf = n_csfall;
        b_ms = n_meas;
        tick(300);
        chk("post_reset_cs_idle", n_csfall - b_cf, 0);
        chk("post_reset_measure", n_meas - b_ms, 0);

        // Link drop in the middle of the fifth frame.
        frame_word = 16'h0123;
        b_sv = n_sv;
        b_wd = n_wd;
        pulse_start();
        tick(429);
        chk("abort_mid_frame", adc_cs_n, 0);
        swiptAlive = 1'b0;
        b_cf = n_csfall;
        tick(1);
        chk("abort_measure", measure, 0);
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_sclk", adc_sclk, 1);
        tick(1200);
        chk("abort_no_done", n_wd - b_wd, 0);
        chk("abort_cnt_hold", sample_cnt, 4);
        chk("abort_valid_count", n_sv - b_sv, 4);
        chk("abort_adc_hold", ADC, 12'h123);
        chk("abort_cs_idle", n_csfall - b_cf, 0);
        swiptAlive = 1'b1;
        tick(5);

        // Second start inside an active window is ignored.
        frame_word = 16'h0456;
        b_sv = n_sv;
        b_wd = n_wd;
        b_ms = n_meas;
        pulse_start();
        tick(489);
        pulse_start();
        tick(1200);
        chk("restart_measure_len", n_meas - b_ms, 1000);
        chk("restart_done_count", n_wd - b_wd, 1);
        chk("restart_cnt", sample_cnt, 10);
        chk("restart_valid_count", n_sv - b_sv, 10);

        // Start while the post-window frame is still on the pins is ignored.
        b_ms = n_meas;
        pulse_start();
        tick(1004);
        pulse_start();
        tick(300);
        chk("inflight_measure_len", n_meas - b_ms, 1000);
        chk("inflight_idle", measure, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
